// File: rtl/tug_light_bar_pkg.sv
// Shared types and helpers for the tug-of-war light bar.
// Holds the game state encoding and the position-to-light decode.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        WIN_L = 2'd1,
        WIN_R = 2'd2
    } tug_state_t;

    // Widest light bar the decode helper supports; callers slice off their N bits.
    localparam int MAX_LIGHTS = 64;

    function automatic logic [MAX_LIGHTS-1:0] onehot_decode(input int idx);
        logic [MAX_LIGHTS-1:0] vec;
        vec = '0;
        if (idx >= 0 && idx < MAX_LIGHTS) begin
            vec[idx] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/tug_light_bar_if.sv
// Button inputs and display outputs of the tug-of-war playfield.
// The game block is the slave; whoever drives the buttons is the master.
interface tug_light_bar_if #(
    parameter int N  = 9,
    parameter int PW = $clog2(N)
);
    logic          lose;
    logic          L;
    logic          R;
    logic [N-1:0]  lights;
    logic          left_win;
    logic          right_win;
    logic [PW-1:0] pos;

    modport master (
        output lose, L, R,
        input  lights, left_win, right_win, pos
    );

    modport slave (
        input  lose, L, R,
        output lights, left_win, right_win, pos
    );
endinterface

// File: rtl/tug_light_bar_button_edge.sv
// Turns a synchronised button level into a single-cycle rise pulse.
// History loads on reset so a button held through reset is not a press.
module button_edge (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic level,
    output logic rise
);

    logic level_q;

    // History only advances while enabled, so a freeze keeps the last sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= level;
        end else if (en) begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/tug_light_bar.sv
// N-light tug-of-war playfield: lit position register, edge-detected
// buttons, one-hot light bar and left/right winner flags.
module tug_light_bar
    import tug_pkg::*;
#(
    parameter int N      = 9,
    parameter int CENTER = N / 2,
    parameter int PW     = $clog2(N)
) (
    input logic            clk,
    input logic            reset,
    tug_light_bar_if.slave bus
);

    tug_state_t    state;
    logic [PW-1:0] pos;
    logic          press_l;
    logic          press_r;
    logic          move_l;
    logic          move_r;
    logic          run;

    localparam logic [PW-1:0] POS_LEFT   = PW'(N - 1);
    localparam logic [PW-1:0] POS_RIGHT  = '0;
    localparam logic [PW-1:0] POS_CENTER = PW'(CENTER);

    assign run = ~bus.lose;

    button_edge u_edge_l (
        .clk   (clk),
        .reset (reset),
        .en    (run),
        .level (bus.L),
        .rise  (press_l)
    );

    button_edge u_edge_r (
        .clk   (clk),
        .reset (reset),
        .en    (run),
        .level (bus.R),
        .rise  (press_r)
    );

    // Simultaneous presses cancel each other out.
    assign move_l = press_l & ~press_r;
    assign move_r = press_r & ~press_l;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PLAY;
            pos   <= POS_CENTER;
        end else if (run && state == PLAY) begin
            if (move_l) begin
                if (pos == POS_LEFT) begin
                    state <= WIN_L;
                end else begin
                    pos <= pos + 1'b1;
                end
            end else if (move_r) begin
                if (pos == POS_RIGHT) begin
                    state <= WIN_R;
                end else begin
                    pos <= pos - 1'b1;
                end
            end
        end
    end

    logic [MAX_LIGHTS-1:0] lit_full;

    // Lights go dark once somebody has won.
    always_comb begin
        lit_full = '0;
        if (state == PLAY) begin
            lit_full = onehot_decode(int'(pos));
        end
    end

    assign bus.lights    = lit_full[N-1:0];
    assign bus.left_win  = (state == WIN_L);
    assign bus.right_win = (state == WIN_R);
    assign bus.pos       = pos;

endmodule
